// File: rtl/adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl
//
// Multi-cycle adder that reuses one SLICE-bit ripple-carry slice per cycle,
// working from the least significant slice upward. The carry between slices
// is kept in a register, so the full-width sum appears after NSLICE cycles.
// This trades latency for a much narrower adder.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst_n      - asynchronous, active-low reset
//   in_valid   - operands a, b, cin are valid
//   in_ready   - block can accept operands (high only in IDLE)
//   a, b       - WIDTH-bit unsigned operands
//   cin        - carry into slice 0
//   out_valid  - sum and cout are valid (high only in DONE)
//   out_ready  - consumer accepts the result
//   sum        - registered result, a + b + cin modulo 2^WIDTH
//   cout       - carry out of the top slice
//   busy       - high in RUN or DONE
// ---------------------------------------------------------------------------
module adder_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    // The slice arithmetic assumes the operand splits evenly into slices;
    // anything else is rejected while the design is being elaborated.
    if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("adder_seq_ctrl: WIDTH must be an integer multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              c_q, c_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [SLICE-1:0]  a_slice;
    logic [SLICE-1:0]  b_slice;
    logic [SLICE:0]    slice_total;
    logic              accept;
    logic              last_slice;

    // Operands are only taken in IDLE; in_valid is ignored everywhere else,
    // so a handshake on the result side can never double as a new accept.
    assign accept     = (state_q == IDLE) && in_valid;
    assign last_slice = (idx_q == LAST_IDX);

    // State register. Reset drops any in-flight operation straight back to
    // IDLE so no partial result can ever be presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN lasts exactly NSLICE cycles, DONE waits as long
    // as the consumer applies backpressure.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)     state_d = RUN;
            RUN:  if (last_slice) state_d = DONE;
            DONE: if (out_ready)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Handshake and status outputs are pure decodes of the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: in_ready  = 1'b1;
            RUN:  busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b1;
        endcase
    end

    // Pick out the operand bits for the slice currently being added. A
    // compare-per-slice mux keeps every part select at a constant offset.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (idx_q == IDXW'(s)) begin
                a_slice = a_q[s*SLICE +: SLICE];
                b_slice = b_q[s*SLICE +: SLICE];
            end
        end
    end

    // The one shared adder slice; its top bit is the carry into the next slice.
    assign slice_total = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, c_q};

    // Datapath update. On accept the operands are latched and the sum is
    // cleared; each RUN cycle fills in one slice of the sum and carries the
    // slice's carry-out forward. The index stops at the last slice instead
    // of wrapping, and the final carry becomes cout.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        idx_d  = idx_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            c_d   = cin;
            idx_d = '0;
            sum_d = '0;
        end else if (state_q == RUN) begin
            for (int s = 0; s < NSLICE; s++) begin
                if (idx_q == IDXW'(s)) begin
                    sum_d[s*SLICE +: SLICE] = slice_total[SLICE-1:0];
                end
            end
            c_d = slice_total[SLICE];
            if (last_slice) begin
                cout_d = slice_total[SLICE];
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            idx_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            idx_q  <= idx_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_seq_ctrl
//
// Self-checking bench for adder_seq_ctrl with the default 16-bit / 2-bit
// slice configuration. Inputs are driven and outputs sampled on the falling
// edge of the clock.
// ---------------------------------------------------------------------------
module tb_adder_seq_ctrl;

    localparam int WIDTH   = 16;
    localparam int LATENCY = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int nAsserts = 0;
    int nFails   = 0;

    adder_seq_ctrl #(.WIDTH(WIDTH), .SLICE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] expSum;
        logic             expCout;
    } vec_t;

    vec_t vecs[10];

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nAsserts++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Records an expired wait as a failed comparison.
    task automatic timeoutFail(input string name);
        nAsserts++;
        nFails++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Presents one operand set as soon as in_ready is seen on a falling edge,
    // holds it across the accepting rising edge, then drops in_valid. Returns
    // on the falling edge just after the accept edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vcin);
        int guard;
        guard = 0;
        while (!in_ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) timeoutFail("wait_in_ready");
        a        = va;
        b        = vb;
        cin      = vcin;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid after an accept, counting falling edges and noting
    // any cycle in which in_ready was high while the add was running.
    task automatic waitResult(output int lat, output int readyHigh);
        lat       = 0;
        readyHigh = 0;
        while (!out_valid && lat < 30) begin
            if (in_ready) readyHigh++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Consumes the result with a single-cycle out_ready pulse and checks the
    // block is back in IDLE on the next cycle.
    task automatic releaseResult(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_idle_in_ready"},  {31'd0, in_ready},  32'd1);
    endtask

    logic [WIDTH-1:0] resSum[3];
    logic             resCout[3];
    int               resCyc[3];
    int               nRes;

    initial begin
        int lat;
        int readyHigh;
        logic [WIDTH:0] model;
        logic [WIDTH-1:0] bbA[3];
        logic [WIDTH-1:0] bbB[3];
        logic             bbC[3];

        vecs[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0};
        vecs[7] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1};
        vecs[8] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0};
        vecs[9] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_busy",      {31'd0, busy},      32'd0);
        checkOutput("rst_sum",       {16'd0, sum},       32'd0);
        checkOutput("rst_cout",      {31'd0, cout},      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
            checkOutput($sformatf("v%0d_busy_run", i), {31'd0, busy}, 32'd1);
            waitResult(lat, readyHigh);
            checkOutput($sformatf("v%0d_latency", i), lat, LATENCY);
            checkOutput($sformatf("v%0d_in_ready_run", i), readyHigh, 0);
            checkOutput($sformatf("v%0d_sum", i),  {16'd0, sum},  {16'd0, vecs[i].expSum});
            checkOutput($sformatf("v%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].expCout});
            releaseResult($sformatf("v%0d", i));
        end

        // Backpressure and input isolation: operands wiggle during RUN and
        // DONE, and the result must stay 0x1111 + 0x2222 = 0x3333.
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        for (int c = 0; c < LATENCY && !out_valid; c++) begin
            in_valid = ~in_valid;
            a        = a + 16'h0101;
            b        = ~b;
            cin      = ~cin;
            @(negedge clk);
        end
        checkOutput("bp_out_valid_reached", {31'd0, out_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            in_valid = ~in_valid;
            a        = a ^ 16'hFFFF;
            @(negedge clk);
            checkOutput($sformatf("bp%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("bp%0d_in_ready", c),  {31'd0, in_ready},  32'd0);
            checkOutput($sformatf("bp%0d_sum", c),       {16'd0, sum},       32'h3333);
            checkOutput($sformatf("bp%0d_cout", c),      {31'd0, cout},      32'd0);
        end
        in_valid = 1'b0;
        releaseResult("bp");
        @(negedge clk);
        checkOutput("bp_no_accept_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of RUN: 0x00FF + 0 has slices 0..2 written
        // (0x003F) after three RUN edges, then everything must clear at once.
        applyStimulus(16'h00FF, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("mid_partial_sum", {16'd0, sum},  32'h003F);
        checkOutput("mid_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_sum",       {16'd0, sum},       32'd0);
        checkOutput("mid_rst_cout",      {31'd0, cout},      32'd0);
        checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("mid_rst_busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LATENCY + 2) @(negedge clk);
        checkOutput("mid_no_stale_result", {31'd0, out_valid}, 32'd0);
        applyStimulus(16'h0005, 16'h0003, 1'b0);
        waitResult(lat, readyHigh);
        checkOutput("mid_after_latency", lat, LATENCY);
        checkOutput("mid_after_sum",  {16'd0, sum},  32'h0008);
        checkOutput("mid_after_cout", {31'd0, cout}, 32'd0);
        releaseResult("mid");

        // Back-to-back with out_ready tied high
        bbA[0] = 16'hABCD; bbB[0] = 16'h1234; bbC[0] = 1'b1;
        bbA[1] = 16'hF00F; bbB[1] = 16'h0FF1; bbC[1] = 1'b0;
        bbA[2] = 16'h0001; bbB[2] = 16'h7FFE; bbC[2] = 1'b1;
        nRes      = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    applyStimulus(bbA[k], bbB[k], bbC[k]);
                end
            end
            begin
                for (int c = 0; c < 45; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (nRes < 3) begin
                            resSum[nRes]  = sum;
                            resCout[nRes] = cout;
                            resCyc[nRes]  = c;
                        end
                        nRes++;
                    end
                end
            end
        join
        out_ready = 1'b0;
        checkOutput("bb_result_count", nRes, 3);
        for (int k = 0; k < 3 && k < nRes; k++) begin
            model = {1'b0, bbA[k]} + {1'b0, bbB[k]} + {{WIDTH{1'b0}}, bbC[k]};
            checkOutput($sformatf("bb%0d_sum", k),  {16'd0, resSum[k]},  {16'd0, model[WIDTH-1:0]});
            checkOutput($sformatf("bb%0d_cout", k), {31'd0, resCout[k]}, {31'd0, model[WIDTH]});
        end
        for (int k = 1; k < 3 && k < nRes; k++) begin
            checkOutput($sformatf("bb%0d_interval", k), resCyc[k] - resCyc[k-1], LATENCY + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands by reusing a SLICE-bit ripple-carry adder slice once per cycle, from the least significant slice upward.
- The carry is registered between slices.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides.
- Trades latency for area: one narrow adder slice instead of a full-width adder.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be an integer multiple of SLICE.
- SLICE, 2, bits added per cycle (width of the reused adder slice).
- NSLICE, WIDTH/SLICE, derived local constant; number of RUN cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to slice 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of the top slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE.
  - All operand registers, the slice index, the carry register, sum and cout clear to 0.
  - in_ready=1, out_valid=0, busy=0.
  - Any in-flight operation is discarded; no partial result is ever presented.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: capture a, b, cin into a_r, b_r, c_r; set idx=0; clear sum; go to RUN.
- RUN (in_ready=0, busy=1):
  - Each cycle, add slice idx: a_r[idx*SLICE +: SLICE] + b_r[same] + c_r.
  - Write the SLICE-bit result into sum[idx*SLICE +: SLICE]; load c_r with that slice's carry-out; idx=idx+1.
  - When the processed idx equals NSLICE-1: load cout with the final carry and go to DONE.
- DONE:
  - out_valid=1; sum and cout stay stable until the result handshake.
  - On out_ready: go to IDLE, so out_valid=0 and in_ready=1 on the next cycle.
  - A new accept cannot occur in the same cycle as the result handshake.
- Latency:
  - Accept edge E0.
  - NSLICE RUN edges follow; out_valid goes high after edge E0+NSLICE (8 cycles for the defaults).
  - Minimum issue interval is NSLICE+2 cycles with out_ready held high.
- Inputs while busy:
  - in_valid, a, b and cin are ignored in RUN and DONE.
  - Operand changes after the accept edge do not affect the result.
- Backpressure: out_ready low in DONE holds the state indefinitely; outputs do not change.
- out_ready outside DONE has no effect.
- Arithmetic:
  - Unsigned; overflow is reported only through cout; no saturation.
  - idx width is clog2(NSLICE), minimum 1 bit; idx never wraps within an operation.
- Configuration check: WIDTH % SLICE != 0 is an elaboration-time error.

Test Plan:
1. Basic add: a=0x1234, b=0x0001, cin=0 -> after 8 cycles out_valid=1, sum=0x1235, cout=0; in_ready=0 throughout RUN.
2. Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry crosses all 8 slices).
3. Max operands: a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1; then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1.
4. Backpressure and input isolation:
   - Hold out_ready=0 for 5 cycles in DONE -> sum and cout stable, out_valid stays 1.
   - Toggle in_valid and change a/b during RUN and DONE -> no accept, result unchanged.
   - Raise out_ready -> IDLE next cycle.
5. Reset mid-operation: assert rst_n=0 asynchronously after 3 RUN cycles -> sum=0, cout=0, out_valid=0, in_ready=1 immediately. After release, a=0x0005, b=0x0003 -> sum=0x0008.
6. Back-to-back with out_ready tied high: three operand pairs presented as soon as in_ready rises -> three correct results, each separated by 10 cycles, none dropped or duplicated; compare every result against a+b+cin.
